// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command front-end: operand/result widths,
// op codes and the sequencer state encoding.
package alu_pkg;

  localparam int unsigned OPND_W  = 3;
  localparam int unsigned RES_W   = 6;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned ENTRY_W = OP_W + 2 * OPND_W;

  // Op codes are forwarded untouched; the sequencer never decodes them.
  localparam logic [OP_W-1:0] OP_AND = 2'b00;
  localparam logic [OP_W-1:0] OP_OR  = 2'b01;
  localparam logic [OP_W-1:0] OP_ADD = 2'b10;
  localparam logic [OP_W-1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapt,
    StResp
  } seq_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Circular command buffer holding {op, a, b} entries; synchronous active-high reset.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic               pop,
  output logic [ENTRY_W-1:0] rdata,
  output logic               full,
  output logic               empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q;
  logic [PtrW-1:0]    rd_ptr_q;
  logic [PtrW:0]      count_q;
  logic               do_push;
  logic               do_pop;

  assign full    = (count_q == (PtrW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + (PtrW + 1)'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - (PtrW + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues each as a one-cycle enable and returns the registered result.
// Optional feature macro ALU_SEQ_CNT_EN adds an 8-bit saturating res_count output.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [OPND_W-1:0] cmd_a,
  input  logic [OPND_W-1:0] cmd_b,
  output logic              alu_en,
  output logic              alu_rst_n,
  output logic [OP_W-1:0]   alu_op,
  output logic [OPND_W-1:0] alu_a,
  output logic [OPND_W-1:0] alu_b,
  input  logic [RES_W-1:0]  alu_dout,
  input  logic              alu_c,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              res_c,
  output logic [OP_W-1:0]   res_op
`ifdef ALU_SEQ_CNT_EN
  ,
  output logic [7:0]        res_count
`endif
);

  seq_state_e         state_q, state_d;
  logic               fifo_full, fifo_empty, fifo_pop;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic [OP_W-1:0]    alu_op_q;
  logic [OPND_W-1:0]  alu_a_q, alu_b_q;
  logic               res_valid_q;
  logic [RES_W-1:0]   res_data_q;
  logic               res_c_q;
  logic [OP_W-1:0]    res_op_q;
  logic               res_xfer;

  assign cmd_ready = !fifo_full && !rst;
  assign fifo_pop  = (state_q == StIdle) && !fifo_empty;
  assign res_xfer  = res_valid_q && res_ready;

  alu_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (cmd_valid && cmd_ready),
    .wdata({cmd_op, cmd_a, cmd_b}),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!fifo_empty) state_d = StIssue;
      StIssue: state_d = StCapt;
      StCapt:  state_d = StResp;
      StResp:  if (res_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_c_q     <= 1'b0;
      res_op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (fifo_pop) begin
        {alu_op_q, alu_a_q, alu_b_q} <= fifo_rdata;
      end
      // The ALU registered its result at the edge closing StIssue.
      if (state_q == StCapt) begin
        res_valid_q <= 1'b1;
        res_data_q  <= alu_dout;
        res_c_q     <= alu_c;
        res_op_q    <= alu_op_q;
      end else if (res_xfer) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  // Enable is forced during reset so the ALU's own reset takes effect.
  assign alu_en    = rst || (state_q == StIssue);
  assign alu_rst_n = ~rst;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_c     = res_c_q;
  assign res_op    = res_op_q;

`ifdef ALU_SEQ_CNT_EN
  logic [7:0] res_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_count_q <= '0;
    end else if (res_xfer && (res_count_q != 8'hff)) begin
      res_count_q <= res_count_q + 8'd1;
    end
  end

  assign res_count = res_count_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural ALU; checks res_count when
// ALU_SEQ_CNT_EN is defined.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_a, cmd_b;
  logic       alu_en, alu_rst_n;
  logic [1:0] alu_op;
  logic [2:0] alu_a, alu_b;
  logic [5:0] alu_dout;
  logic       alu_c;
  logic       res_valid, res_ready;
  logic [5:0] res_data;
  logic       res_c;
  logic [1:0] res_op;
`ifdef ALU_SEQ_CNT_EN
  logic [7:0] res_count;
`endif

  alu_cmd_sequencer #(
    .DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_a    (cmd_a),
    .cmd_b    (cmd_b),
    .alu_en   (alu_en),
    .alu_rst_n(alu_rst_n),
    .alu_op   (alu_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_dout (alu_dout),
    .alu_c    (alu_c),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_c    (res_c),
    .res_op   (res_op)
`ifdef ALU_SEQ_CNT_EN
    ,
    .res_count(res_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference arithmetic: full 6-bit result, no truncation.
  function automatic logic [5:0] ref_fn(input logic [1:0] op, input logic [2:0] a,
                                        input logic [2:0] b);
    int r;
    case (op)
      2'b00:   r = int'(a) & int'(b);
      2'b01:   r = int'(a) | int'(b);
      2'b10:   r = int'(a) + int'(b);
      default: r = int'(a) - int'(b);
    endcase
    return r[5:0];
  endfunction

  // Behavioural ALU bank: registers on enable, reset only acts when enabled.
  logic [5:0] alu_q;
  always @(posedge clk) begin
    if (alu_en) alu_q <= !alu_rst_n ? 6'd0 : ref_fn(alu_op, alu_a, alu_b);
  end
  assign alu_dout = alu_q;
  assign alu_c    = alu_q[3];

  typedef struct packed {
    logic [1:0] op;
    logic [5:0] data;
    logic       c;
  } exp_t;

  exp_t exp_q[$];
  int   rise_q[$];
  int   errors = 0, checks = 0;
  int   cyc = 0;
  int   acc_cnt = 0, xfer_cnt = 0, en_cnt = 0;
  int   last_acc = 0, last_rise = 0;
  int   cnt_model = 0;
  logic prev_valid = 0, prev_ready = 0, prev_en = 0, prev_c = 0;
  logic [5:0] prev_data = 0;
  logic [1:0] prev_op = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Monitor/scoreboard: samples on the falling edge, i.e. the values the next rising edge sees.
  always @(negedge clk) begin
    exp_t e, got;
    if (rst) begin
      exp_q.delete();
      cnt_model  = 0;
      prev_valid = 0;
      prev_en    = 0;
    end else begin
`ifdef ALU_SEQ_CNT_EN
      chk("res_count", res_count, cnt_model);
`endif
      if (cmd_valid && cmd_ready) begin
        e.op   = cmd_op;
        e.data = ref_fn(cmd_op, cmd_a, cmd_b);
        e.c    = e.data[3];
        exp_q.push_back(e);
        acc_cnt++;
        last_acc = cyc + 1;
      end
      if (alu_en) begin
        en_cnt++;
        chk("alu_en_single_cycle", prev_en, 0);
      end
      if (res_valid) chk("alu_en_idle_in_resp", alu_en, 0);
      if (res_valid && !prev_valid) begin
        last_rise = cyc;
        rise_q.push_back(cyc);
      end
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", res_valid, 1);
        chk("hold_data", res_data, prev_data);
        chk("hold_c", res_c, prev_c);
        chk("hold_op", res_op, prev_op);
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          timeout_fail("unexpected_result");
        end else begin
          e = exp_q.pop_front();
          got.op = res_op; got.data = res_data; got.c = res_c;
          chk("result", got, e);
        end
        xfer_cnt++;
        if (cnt_model < 255) cnt_model++;
      end
      prev_valid = res_valid;
      prev_ready = res_ready;
      prev_data  = res_data;
      prev_c     = res_c;
      prev_op    = res_op;
      prev_en    = alu_en;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
    bit ok = 0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    @(posedge clk);
    #1;
    cmd_valid = 0;
    if (!ok) timeout_fail("cmd_accept");
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      step(1);
      if (exp_q.size() == 0 && !res_valid) return;
    end
    timeout_fail("drain");
  endtask

  bit sender_done;
  int snap, en_snap;

  initial begin
    rst = 1; cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; res_ready = 0;
    step(3);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_alu_en", alu_en, 1);
    chk("rst_alu_rst_n", alu_rst_n, 0);
    chk("rst_outputs", {res_valid, res_data, res_c, res_op, alu_op, alu_a, alu_b}, 0);
    rst = 0;
    step(1);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_alu_en", alu_en, 0);
    chk("post_rst_alu_rst_n", alu_rst_n, 1);

    // Single add: 3 + 5 = 8, carry flag set.
    res_ready = 1;
    snap = en_cnt;
    send(OP_ADD, 3'd3, 3'd5);
    drain();
    chk("single_latency", last_rise - last_acc, 3);
    chk("single_en_pulses", en_cnt - snap, 1);

    // Back-to-back: 14 then 3, four cycles apart.
    send(OP_ADD, 3'd7, 3'd7);
    send(OP_ADD, 3'd2, 3'd1);
    drain();
    chk("b2b_spacing", rise_q[rise_q.size()-1] - rise_q[rise_q.size()-2], 4);

    // Fill under backpressure: 5 accepted, then drain in order with the 6th.
    res_ready = 0;
    snap = acc_cnt;
    sender_done = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(2'(i), 3'(i + 1), 3'(6 - i));
        sender_done = 1;
      end
    join_none
    step(12);
    chk("fill_accepted", acc_cnt - snap, 5);
    chk("fill_cmd_ready", cmd_ready, 0);
    en_snap = en_cnt;
    step(10);
    chk("backpressure_no_issue", en_cnt - en_snap, 0);
    chk("backpressure_valid", res_valid, 1);
    res_ready = 1;
    for (int t = 0; t < 300 && !sender_done; t++) step(1);
    if (!sender_done) timeout_fail("fill_sender");
    drain();
    chk("fill_all_accepted", acc_cnt - snap, 6);

    // Reset while the command is in ISSUE: nothing comes out.
    send(OP_ADD, 3'd4, 3'd4);
    begin
      bit seen = 0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (alu_en) begin seen = 1; break; end
      end
      if (!seen) timeout_fail("wait_issue");
    end
    #1;
    rst = 1;
    #1;
    chk("mid_rst_alu_en", alu_en, 1);
    chk("mid_rst_alu_rst_n", alu_rst_n, 0);
    snap = xfer_cnt;
    step(1);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    step(1);
    rst = 0;
    #1;
    chk("mid_rst_release_ready", cmd_ready, 1);
    step(8);
    chk("mid_rst_no_result", xfer_cnt - snap, 0);
    chk("mid_rst_alu_cleared", alu_dout, 0);

    // Randomised traffic with random gaps and backpressure.
    sender_done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          step($urandom_range(0, 3));
          send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        sender_done = 1;
      end
      begin
        for (int t = 0; t < 5000 && !sender_done; t++) begin
          step(1);
          res_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    res_ready = 1;
    drain();
    chk("final_scoreboard_empty", exp_q.size(), 0);
    chk("final_xfer_vs_accept", xfer_cnt, acc_cnt - 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Front-end stage sitting directly upstream of the ALU function units (add and sibling ops).
- Accepts operand/op commands over a valid/ready handshake and buffers them in a small FIFO.
- Issues each command to the ALU bank as a one-cycle enable pulse, captures the ALU's registered result one cycle later, and presents it downstream with valid/ready.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command FIFO can accept
cmd_op  in  2  ALU op select (forwarded unchanged)
cmd_a  in  3  operand A
cmd_b  in  3  operand B
alu_en  out  1  ALU enable pulse
alu_rst_n  out  1  ALU reset, active-low
alu_op  out  2  op to ALU bank
alu_a  out  3  operand A to ALU bank
alu_b  out  3  operand B to ALU bank
alu_dout  in  6  selected ALU result (registered in ALU)
alu_c  in  1  ALU carry flag (result bit 3)
res_valid  out  1  result available
res_ready  in  1  downstream accepts result
res_data  out  6  captured result
res_c  out  1  captured carry
res_op  out  2  op that produced result

Behaviour:
- Handshakes:
  - Command transfer on an edge with cmd_valid && cmd_ready.
  - Result transfer on an edge with res_valid && res_ready.
  - A transfer happens only at that edge.
- cmd_ready = !fifo_full && !rst.
  - Full/pop same cycle: the push is still refused; ready reflects the pre-edge count.
- FIFO:
  - Circular buffer, wrap-around pointers, count 0..DEPTH.
  - Push into an empty FIFO is not bypassed.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into alu_op/alu_a/alu_b, go to ISSUE; else stay.
  - ISSUE: alu_en=1 for exactly this cycle; the ALU registers at the closing edge; go to CAPT.
  - CAPT: alu_en=0. Latch alu_dout->res_data, alu_c->res_c, alu_op->res_op; set res_valid; go to RESP.
  - RESP: hold res_* stable while res_valid && !res_ready. On transfer clear res_valid, go to IDLE.
- Latency and throughput:
  - Command accepted at edge k -> res_valid high after edge k+3.
  - Throughput is 1 command / 4 cycles with res_ready held high.
- Results leave in acceptance order. No op decode; all op codes take identical latency (add = 2'b10).
- Widths: no truncation. res_data is the full 6-bit ALU output, e.g. 7+7 = 6'd14.
- Reset (any cycle, including mid-operation):
  - State -> IDLE. FIFO emptied. In-flight command discarded; no result emitted.
  - Output reset values: res_valid=0, res_data=0, res_c=0, res_op=0, alu_op=0, alu_a=0, alu_b=0, cmd_ready=0.
  - alu_rst_n = ~rst (combinational). alu_en = 1 while rst is high, so the ALU clears; ALU reset only acts when enabled.
  - First edge with rst low: cmd_ready=1.

Optional Feature:
- Macro ALU_SEQ_CNT_EN.
- Defined:
  - Adds output port res_count (8 bits), counting completed result transfers.
  - Saturates at 255 and is cleared by rst.
  - Increments on the same edge as the result transfer.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - Op constants: OP_ADD = 2'b10 plus sibling op codes.
  - Widths: OPND_W = 3, RES_W = 6, OP_W = 2.
  - FSM state encoding for IDLE/ISSUE/CAPT/RESP.
- One sub-module, alu_cmd_fifo:
  - Parameterised by DEPTH; 8-bit entry {op, a, b}.
  - Ports: push, pop, full, empty, synchronous active-high reset.
- FSM and output registers live in the top.

Test Plan:
- Single add: op=2'b10, A=3, B=5, res_ready=1 -> alu_en high exactly 1 cycle; res_valid 3 cycles after accept; res_data=6'd8, res_c=1, res_op=2'b10.
- Back-to-back: A=7,B=7 then A=2,B=1 -> res_data 14 (res_c=1) then 3 (res_c=0), in order, 4-cycle spacing.
- Fill FIFO: res_ready=0, cmd_valid held with 6 commands -> 5 accepted (1 in RESP + 4 queued), cmd_ready low. Raise res_ready -> all 5 results in order; 6th accepted on the first freed slot.
- Backpressure: res_ready=0 for 10 cycles in RESP -> res_valid, res_data, res_c, res_op stable; alu_en stays 0.
- Reset during ISSUE -> next cycle res_valid=0, FIFO empty; alu_en=1 and alu_rst_n=0 while rst high; no result emitted; cmd_ready=1 after rst drops.
- With ALU_SEQ_CNT_EN: 3 completed transfers -> res_count=3; reset -> 0. Without the macro: elaboration has no res_count port.
